// File: rtl/wb_commit_tracer.sv
// Writeback commit tracer: buffers architectural register writes in a FIFO and
// streams each as a 5-byte record {101,dest} value[31:24..7:0] over a valid/ready byte port.
module wb_commit_tracer #(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wwreg,
    input  logic                     wm2reg,
    input  logic [4:0]               wdestReg,
    input  logic [31:0]              wr,
    input  logic [31:0]              wdo,
    input  logic                     enable,
    input  logic                     clear_stats,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [36:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [2:0]    byte_idx;
    logic [36:0]   head;
    logic          commit;
    logic          xfer;
    logic          pop;
    logic          full;
    logic          push;
    logic          drop;

    assign commit   = enable & wwreg & (wdestReg != 5'd0);
    assign tx_valid = (fifo_count != '0);
    assign xfer     = tx_valid & tx_ready;
    assign pop      = xfer & (byte_idx == 3'd4);
    assign full     = (fifo_count == CW'(DEPTH));
    // A full FIFO still takes a commit when the head's last byte leaves on the same edge.
    assign push     = commit & (~full | pop);
    assign drop     = commit & ~push;
    assign head     = mem[rd_ptr];

    // NOTE: the record storage has no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {wdestReg, (wm2reg ? wdo : wr)};
        end
    end

    // NOTE: tx_data gets a default before the case so no latch is inferred.
    always_comb begin
        tx_data = 8'h00;
        if (tx_valid) begin
            unique case (byte_idx)
                3'd0:    tx_data = {3'b101, head[36:32]};
                3'd1:    tx_data = head[31:24];
                3'd2:    tx_data = head[23:16];
                3'd3:    tx_data = head[15:8];
                3'd4:    tx_data = head[7:0];
                default: tx_data = 8'h00;
            endcase
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            byte_idx   <= 3'd0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                byte_idx <= 3'd0;
            end else if (xfer) begin
                byte_idx <= byte_idx + 3'd1;
            end
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // A drop coinciding with clear_stats is counted after the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear_stats) begin
            overflow   <= drop;
            drop_count <= drop ? DROP_W'(1) : '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

endmodule

// File: doc/wb_commit_tracer.md
# wb_commit_tracer

Captures every architectural register write leaving the writeback stage of the 5-stage pipelined datapath. Buffers each write in a FIFO and streams it out as 5-byte records over an 8-bit valid/ready byte interface for a debug host or a trace-checking bench. The writeback stage writes register state; this block reads that state. It sits beside the datapath, fed from the writeback pipeline-register outputs, and never stalls the pipeline.

## Interface
- DEPTH, 8, FIFO depth in records; power of two, ≥2
- DROP_W, 16, width of the saturating drop counter
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous and active-low
- wwreg  in  1  writeback register-write enable
- wm2reg  in  1  writeback source select: 1 = memory data, 0 = ALU result
- wdestReg  in  5  writeback destination register
- wr  in  32  writeback ALU result
- wdo  in  32  writeback memory data
- enable  in  1  capture enable; draining continues regardless
- clear_stats  in  1  synchronous clear of overflow and drop_count
- tx_data  out  8  current trace byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  consumer accepts byte
- fifo_count  out  log2(DEPTH)+1  records held, including the one being sent
- overflow  out  1  sticky: a commit was dropped
- drop_count  out  DROP_W  dropped commits, saturating at all-ones

## Operation
- Commit condition: enable & wwreg & (wdestReg != 0). Writes to x0 are never traced.
- Record value = wm2reg ? wdo : wr. Record = {dest[4:0], value[31:0]}, stored in the FIFO at the rising edge.
- Byte order per record: byte0 = {3'b101, dest}; bytes 1–4 = value[31:24], [23:16], [15:8], [7:0].
- Serializer: byte index register 0..4, and no separate load state. tx_data is muxed from the FIFO head by index. tx_valid = (fifo_count != 0).
- Handshake: a byte transfers on an edge where tx_valid & tx_ready. The index increments on transfer. On transfer of byte 4 the index wraps to 0 and the head is popped.
- While tx_valid & !tx_ready, tx_data and the index hold.
- Full: a commit arriving with fifo_count == DEPTH is accepted only if byte 4 of the head transfers on the same edge. fifo_count then stays DEPTH.
- Otherwise the commit is dropped: overflow sets, and drop_count increments until it is all-ones, then holds.
- Simultaneous push and pop when not full: fifo_count unchanged. Both pointers advance and wrap modulo DEPTH.
- clear_stats: overflow ← 0 and drop_count ← 0. If a drop occurs on the same edge, the drop is counted after the clear: overflow = 1, drop_count = 1.
- Deasserting enable mid-record does not affect draining of records already buffered.

## Timing
- Reset (asynchronous, rst_n = 0): FIFO empty, pointers 0, byte index 0, fifo_count = 0, tx_valid = 0, overflow = 0, drop_count = 0. tx_data = 8'h00 while empty.
- Reset mid-record discards all buffered and partially sent records. The first record after reset restarts at byte0.
- Capture latency: a commit sampled at edge N is visible (tx_valid = 1, byte0 on tx_data) in the cycle after edge N, if the FIFO was empty.
- Throughput with tx_ready held high: one byte per cycle, one record per 5 cycles. Sustained commits faster than one per 5 cycles eventually overflow.
- fifo_count, overflow and drop_count are registered and update on the same edge as the push, pop or drop.

## Test plan
- Single commit: wwreg = 1, wm2reg = 0, wdestReg = 5, wr = 32'hDEADBEEF, tx_ready = 1 → bytes A5, DE, AD, BE, EF on consecutive cycles starting the cycle after capture. fifo_count goes 1 then 0 after byte 4.
- Filtering: commit to x0, commit with wwreg = 0, and commit with enable = 0 → tx_valid stays 0 and fifo_count stays 0. Commit with wm2reg = 1, wdo = 32'h00000042, wr = 32'h11111111, dest = 31 → bytes BF, 00, 00, 00, 42.
- Backpressure: one record with tx_ready low for 3 cycles after byte1 → byte2 held stable on tx_data with tx_valid = 1 for all 3 cycles. The record then completes intact.
- Overflow: tx_ready = 0, 10 consecutive valid commits with DEPTH = 8 → fifo_count = 8, drop_count = 2, overflow = 1. Records 1–8 drain in order. Then clear_stats → drop_count = 0, overflow = 0.
- Full plus simultaneous pop: FIFO full, head at byte 4, tx_ready = 1 with a new commit on the same edge → commit accepted, fifo_count = 8, drop_count unchanged.
- Reset mid-record: assert rst_n = 0 after byte2 of a record with 3 records buffered → tx_valid = 0 and fifo_count = 0 immediately. After release, a new commit streams starting at byte0.
